// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM states and JEDEC ID byte selection for the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_ID,
        ST_STAT,
        ST_IGNORE
    } state_e;

    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd0:    return id[23:16];
            2'd1:    return id[15:8];
            default: return id[7:0];
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus a third flop for rise/fall detection of an async level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sh_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_q <= {3{RST_VAL}};
        end else begin
            sh_q <= {sh_q[1:0], d_i};
        end
    end

    assign rise_o = sh_q[1] & ~sh_q[2];
    assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 slave emulating a serial NOR flash: READ, RDID and RDSR served from a byte memory port.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int unsigned ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter logic [7:0]  STATUS   = 8'h00
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sck,
    input  logic              i_csn,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_miso_oe,
    output logic              o_mem_re,
    output logic [ADDR_W-1:0] o_mem_adr,
    input  logic [7:0]        i_mem_dat,
    output logic              o_cmd_err
);

    logic              sck_rise;
    logic              sck_fall;
    logic [1:0]        csn_sync_q;
    logic [1:0]        mosi_sync_q;
    logic              csn_s;
    logic              mosi_s;
    logic              csn_prev_q;

    state_e            state_q;
    logic [2:0]        bit_cnt_q;
    logic [1:0]        byte_cnt_q;
    logic [22:0]       rx_q;
    logic [7:0]        tx_q;
    logic [1:0]        id_idx_q;
    logic              rd_pend_q;
    logic              miso_q;
    logic              miso_oe_q;
    logic              mem_re_q;
    logic [ADDR_W-1:0] mem_adr_q;
    logic              cmd_err_q;

    logic [23:0]       rx_full_d;
    logic [7:0]        rx_byte_d;
    logic [1:0]        id_idx_d;

    spi_sync_edge #(
        .RST_VAL (1'b0)
    ) u_sck_sync (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .d_i    (i_sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // CSn resets to its idle (deselected) level so reset release never fakes a frame start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
        end else begin
            csn_sync_q  <= {csn_sync_q[0], i_csn};
            mosi_sync_q <= {mosi_sync_q[0], i_mosi};
        end
    end

    assign csn_s  = csn_sync_q[1];
    assign mosi_s = mosi_sync_q[1];

    always_comb begin
        rx_full_d = {rx_q, mosi_s};
        rx_byte_d = rx_full_d[7:0];
        id_idx_d  = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            id_idx_q   <= '0;
            rd_pend_q  <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_adr_q  <= '0;
            cmd_err_q  <= 1'b0;
            csn_prev_q <= 1'b1;
        end else begin
            csn_prev_q <= csn_s;
            mem_re_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            rd_pend_q  <= mem_re_q;

            if (csn_s) begin
                state_q    <= ST_IDLE;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                miso_q     <= 1'b0;
                miso_oe_q  <= 1'b0;
                rd_pend_q  <= 1'b0;
            end else begin
                if (rd_pend_q && state_q == ST_DATA) begin
                    tx_q <= i_mem_dat;
                end

                case (state_q)
                    ST_IDLE: begin
                        if (csn_prev_q) begin
                            state_q <= ST_CMD;
                        end
                    end

                    ST_CMD: begin
                        if (sck_rise) begin
                            rx_q      <= rx_full_d[22:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                case (rx_byte_d)
                                    OP_READ: begin
                                        state_q    <= ST_ADDR;
                                        byte_cnt_q <= '0;
                                    end
                                    OP_RDID: begin
                                        state_q  <= ST_ID;
                                        id_idx_q <= '0;
                                        tx_q     <= id_byte(JEDEC_ID, 2'd0);
                                    end
                                    OP_RDSR: begin
                                        state_q <= ST_STAT;
                                        tx_q    <= STATUS;
                                    end
                                    default: begin
                                        state_q   <= ST_IGNORE;
                                        cmd_err_q <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end

                    ST_ADDR: begin
                        if (sck_rise) begin
                            rx_q      <= rx_full_d[22:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (byte_cnt_q == 2'd2) begin
                                    mem_adr_q  <= rx_full_d[ADDR_W-1:0];
                                    mem_re_q   <= 1'b1;
                                    byte_cnt_q <= '0;
                                    state_q    <= ST_DATA;
                                end else begin
                                    byte_cnt_q <= byte_cnt_q + 2'd1;
                                end
                            end
                        end
                    end

                    // bit_cnt keeps counting rises, so a fall seen at bit_cnt==7 drives the last bit of a byte.
                    ST_DATA, ST_ID, ST_STAT: begin
                        if (sck_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end else if (sck_fall) begin
                            miso_q    <= tx_q[7];
                            miso_oe_q <= 1'b1;
                            tx_q      <= {tx_q[6:0], 1'b0};
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == ST_DATA) begin
                                    mem_adr_q <= mem_adr_q + ADDR_W'(1);
                                    mem_re_q  <= 1'b1;
                                end else if (state_q == ST_ID) begin
                                    id_idx_q <= id_idx_d;
                                    tx_q     <= id_byte(JEDEC_ID, id_idx_d);
                                end else begin
                                    tx_q <= STATUS;
                                end
                            end
                        end
                    end

                    ST_IGNORE: begin
                        miso_oe_q <= 1'b0;
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_miso    = miso_q;
    assign o_miso_oe = miso_oe_q;
    assign o_mem_re  = mem_re_q;
    assign o_mem_adr = mem_adr_q;
    assign o_cmd_err = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master model, byte-addressed memory model (byte[n]=n).
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        csn;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic        mem_re;
    logic [23:0] mem_adr;
    logic [7:0]  mem_dat = 8'h00;
    logic        cmd_err;

    int          n_vec = 0;
    int          n_err = 0;
    int          re_cnt = 0;
    int          err_cnt = 0;
    logic [23:0] re_adr[$];

    spi_flash_responder #(
        .ADDR_W   (24),
        .JEDEC_ID (24'hEF4016),
        .STATUS   (8'h00)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_sck     (sck),
        .i_csn     (csn),
        .i_mosi    (mosi),
        .o_miso    (miso),
        .o_miso_oe (miso_oe),
        .o_mem_re  (mem_re),
        .o_mem_adr (mem_adr),
        .i_mem_dat (mem_dat),
        .o_cmd_err (cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) begin
            mem_dat <= mem_adr[7:0];
            re_cnt  <= re_cnt + 1;
            re_adr.push_back(mem_adr);
        end
        if (cmd_err) begin
            err_cnt <= err_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Mode 0: MISO sampled just before each rising edge, MOSI changed while SCK is low.
    task automatic xfer(input logic [7:0] txb, input int nbits,
                        output logic [7:0] rxb, output logic oe_and, output logic oe_or);
        rxb    = '0;
        oe_and = 1'b1;
        oe_or  = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = txb[7-i];
            #40;
            rxb    = {rxb[6:0], miso};
            oe_and = oe_and & miso_oe;
            oe_or  = oe_or | miso_oe;
            sck    = 1'b1;
            #80;
            sck = 1'b0;
            #40;
        end
    endtask

    task automatic cs_start();
        csn = 1'b0;
        #100;
    endtask

    task automatic cs_end();
        #40;
        csn = 1'b1;
        #200;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rx;
        logic       oa;
        logic       oo;
        logic       oe_acc;
        int         base_re;
        int         base_q;
        int         base_err;
        logic [7:0] id_exp[6];

        id_exp[0] = 8'hEF; id_exp[1] = 8'h40; id_exp[2] = 8'h16;
        id_exp[3] = 8'hEF; id_exp[4] = 8'h40; id_exp[5] = 8'h16;

        rst = 1'b1; csn = 1'b1; sck = 1'b0; mosi = 1'b0;
        #22;
        chk("rst_miso",    miso,    0);
        chk("rst_oe",      miso_oe, 0);
        chk("rst_re",      mem_re,  0);
        chk("rst_adr",     mem_adr, 0);
        chk("rst_cmd_err", cmd_err, 0);
        #20;
        rst = 1'b0;
        #100;

        // READ 0x000010, four data bytes
        base_re = re_cnt;
        cs_start();
        xfer(8'h03, 8, rx, oa, oo); oe_acc = oo;
        xfer(8'h00, 8, rx, oa, oo); oe_acc = oe_acc | oo;
        xfer(8'h00, 8, rx, oa, oo); oe_acc = oe_acc | oo;
        xfer(8'h10, 8, rx, oa, oo); oe_acc = oe_acc | oo;
        chk("rd_hdr_oe", oe_acc, 0);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, 8, rx, oa, oo);
            chk("rd_dat", rx, 32'h10 + i);
            chk("rd_dat_oe", oa, 1);
        end
        cs_end();
        chk("rd_re_cnt",  re_cnt - base_re, 5);
        chk("rd_adr_end", mem_adr, 24'h000014);
        chk("rd_oe_off",  miso_oe, 0);

        // RDID, six bytes wrap the 3-byte ID
        cs_start();
        xfer(8'h9F, 8, rx, oa, oo);
        chk("id_op_oe", oo, 0);
        for (int i = 0; i < 6; i++) begin
            xfer(8'h00, 8, rx, oa, oo);
            chk("id_dat", rx, id_exp[i]);
        end
        cs_end();

        // RDSR
        cs_start();
        xfer(8'h05, 8, rx, oa, oo);
        chk("sr_op_oe", oo, 0);
        for (int i = 0; i < 2; i++) begin
            xfer(8'hFF, 8, rx, oa, oo);
            chk("sr_dat", rx, 8'h00);
            chk("sr_dat_oe", oa, 1);
        end
        chk("sr_oe_before_cs", miso_oe, 1);
        cs_end();
        chk("sr_oe_after_cs", miso_oe, 0);

        // Unsupported opcode then recovery
        base_err = err_cnt;
        cs_start();
        xfer(8'hAB, 8, rx, oa, oo); oe_acc = oo;
        xfer(8'h03, 8, rx, oa, oo); oe_acc = oe_acc | oo;
        xfer(8'h9F, 8, rx, oa, oo); oe_acc = oe_acc | oo;
        chk("bad_oe", oe_acc | miso_oe, 0);
        cs_end();
        chk("bad_err_cnt", err_cnt - base_err, 1);
        cs_start();
        xfer(8'h9F, 8, rx, oa, oo);
        xfer(8'h00, 8, rx, oa, oo);
        chk("bad_then_id", rx, 8'hEF);
        cs_end();

        // READ at the top of the address space wraps to zero
        base_q = re_adr.size();
        cs_start();
        xfer(8'h03, 8, rx, oa, oo);
        xfer(8'hFF, 8, rx, oa, oo);
        xfer(8'hFF, 8, rx, oa, oo);
        xfer(8'hFF, 8, rx, oa, oo);
        xfer(8'h00, 8, rx, oa, oo);
        chk("wrap_dat0", rx, 8'hFF);
        xfer(8'h00, 8, rx, oa, oo);
        chk("wrap_dat1", rx, 8'h00);
        cs_end();
        chk("wrap_nreads", re_adr.size() - base_q, 3);
        chk("wrap_adr0", re_adr[base_q],     24'hFFFFFF);
        chk("wrap_adr1", re_adr[base_q + 1], 24'h000000);

        // CSn raised 3 bits into the second data byte
        base_re = re_cnt;
        cs_start();
        xfer(8'h03, 8, rx, oa, oo);
        xfer(8'h00, 8, rx, oa, oo);
        xfer(8'h00, 8, rx, oa, oo);
        xfer(8'h20, 8, rx, oa, oo);
        xfer(8'h00, 8, rx, oa, oo);
        chk("abort_dat0", rx, 8'h20);
        xfer(8'h00, 3, rx, oa, oo);
        chk("abort_part", rx, 8'h01);
        cs_end();
        #400;
        chk("abort_re_cnt", re_cnt - base_re, 2);
        chk("abort_oe",     miso_oe, 0);
        chk("abort_miso",   miso, 0);

        // Reset pulsed in the middle of a new READ header
        base_re = re_cnt;
        cs_start();
        xfer(8'h03, 8, rx, oa, oo);
        xfer(8'h00, 8, rx, oa, oo);
        rst = 1'b1;
        #30;
        chk("mid_rst_oe",  miso_oe, 0);
        chk("mid_rst_adr", mem_adr, 0);
        rst = 1'b0;
        #200;
        csn = 1'b1;
        #400;
        chk("mid_rst_no_re", re_cnt - base_re, 0);
        chk("mid_rst_oe2",   miso_oe, 0);

        base_q = re_adr.size();
        cs_start();
        xfer(8'h03, 8, rx, oa, oo);
        xfer(8'h00, 8, rx, oa, oo);
        xfer(8'h00, 8, rx, oa, oo);
        xfer(8'h00, 8, rx, oa, oo);
        xfer(8'h00, 8, rx, oa, oo);
        chk("post_rst_dat0", rx, 8'h00);
        xfer(8'h00, 8, rx, oa, oo);
        chk("post_rst_dat1", rx, 8'h01);
        cs_end();
        chk("post_rst_adr0", re_adr[base_q], 24'h000000);
        chk("total_cmd_err", err_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- SPI mode-0 slave that emulates a serial NOR flash. It is the target end of the flash SPI link driven by the on-chip SPI master.
- Used in simulation and FPGA builds to boot without a physical flash device.
- Serves READ (0x03), RDID (0x9F) and RDSR (0x05) from a byte-wide synchronous memory port.
- SCK, CSn and MOSI are oversampled in the system clock domain.

Parameters:
- ADDR_W, 24, memory address width; address bytes beyond ADDR_W bits are dropped (MSBs).
- JEDEC_ID, 24'hEF4016, 3-byte ID returned by RDID, MSB byte first.
- STATUS, 8'h00, constant status byte returned by RDSR.

Ports:
- i_clk  in  1  system clock; must be at least 8x the SCK frequency.
- i_rst  in  1  reset, asynchronous, active-high.
- i_sck  in  1  SPI clock, asynchronous to i_clk.
- i_csn  in  1  SPI chip select, active-low, asynchronous.
- i_mosi  in  1  SPI data in.
- o_miso  out  1  SPI data out.
- o_miso_oe  out  1  MISO drive enable.
- o_mem_re  out  1  one-cycle memory read strobe.
- o_mem_adr  out  ADDR_W  memory byte address.
- i_mem_dat  in  8  read data, valid exactly 1 cycle after o_mem_re.
- o_cmd_err  out  1  one-cycle pulse when an unsupported opcode completes.

Behaviour:
- Input synchronisation:
  - i_sck, i_csn and i_mosi each pass through a 2-flop synchroniser.
  - Rise and fall of the synchronised SCK are detected against a third flop.
  - MOSI is sampled on the detected rise.
  - MISO shifts on the detected fall.
- Reset values: all outputs 0; state IDLE; all counters 0. Asynchronous reset aborts any transfer immediately.
- CSn high (synchronised):
  - Forces state IDLE, bit_cnt=0, o_miso_oe=0 and o_miso=0 in the next cycle.
  - Any partial byte is discarded.
  - This has priority over a simultaneous SCK edge.
- bit_cnt (3-bit) counts sampled bits. A byte completes when bit_cnt wraps from 7 to 0; MSB first.
- States:
  - IDLE -> CMD on synchronised CSn falling.
  - CMD, on byte complete:
    - 0x03 -> ADDR.
    - 0x9F -> ID (idx=0).
    - 0x05 -> STAT.
    - Any other opcode -> IGNORE, with o_cmd_err pulsed for 1 cycle.
  - ADDR:
    - Shifts 3 bytes; byte_cnt (2-bit) counts 0..2.
    - On the third byte complete: load o_mem_adr from the low ADDR_W bits of the 24 received bits, assert o_mem_re for 1 cycle, go to DATA.
  - DATA:
    - The cycle after o_mem_re, i_mem_dat is loaded into the tx shift register.
    - On each following SCK fall, drive tx[7] and shift left.
    - After the 8th bit is driven, the address increments modulo 2^ADDR_W and a new read is issued. Its data loads before the next byte's first fall.
    - Continues until CSn rises.
  - ID: outputs JEDEC_ID[23:16], [15:8], [7:0], then repeats from [23:16].
  - STAT: outputs STATUS repeatedly.
  - IGNORE: MOSI is ignored, o_miso_oe=0, until CSn rises.
- MISO framing (mode 0):
  - The first response bit is driven on the SCK fall that follows the rise sampling the last opcode/address bit.
  - o_miso_oe goes to 1 at that fall and stays 1 until CSn rises.
- Timing requirement: SCK high and low times must each be at least 4 i_clk cycles. This covers 3-cycle detect latency plus 1-cycle memory latency.
- Address wrap: 0xFFFFFF + 1 -> 0x000000 with no error.
- CSn rising mid-byte in DATA: an outstanding o_mem_re result is dropped; no further reads.

Decomposition:
- Package spi_flash_pkg:
  - Opcode constants OP_READ=8'h03, OP_RDID=8'h9F, OP_RDSR=8'h05.
  - State enumeration constants.
- Sub-module spi_sync_edge: 3-flop synchroniser with rise/fall detect. Instantiated for SCK; plain 2-flop sync used for CSn/MOSI.

Test Plan:
- READ 0x03, addr 0x000010, memory byte[n]=n, 4 bytes clocked -> MISO returns 0x10,0x11,0x12,0x13; o_mem_re pulses 4 (+1 prefetch) times; o_mem_adr ends 0x000014.
- RDID 0x9F, 6 bytes clocked -> 0xEF,0x40,0x16,0xEF,0x40,0x16.
- RDSR 0x05, 2 bytes -> 0x00,0x00; o_miso_oe high from the first fall after the opcode until CSn high.
- Opcode 0xAB -> o_cmd_err pulses exactly once; o_miso_oe stays 0; 2 trailing bytes ignored; next frame with 0x9F returns 0xEF.
- READ at 0xFFFFFF, 2 bytes -> o_mem_adr 0xFFFFFF then 0x000000.
- CSn raised after 3 bits of the second data byte, then i_rst pulsed mid-frame of a new READ -> state IDLE, o_miso_oe=0, no o_mem_re after the abort; the subsequent READ 0x000000 returns mem[0].
